// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement queue between rename/dispatch and the physical-register
//   free list. Each dispatched instruction takes the tail entry. The head entry
//   retires once it is marked done. A branch mispredict cuts the tail back to
//   just after the branch, which squashes every younger entry.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   dispatch_valid/ready            rename handshake (ready = an entry is free)
//   dispatch_has_dest/areg/new_preg/old_preg  payload of the dispatching entry
//   dispatch_rob_idx                tag given to the dispatching instruction
//   complete_valid/complete_rob_idx marks one entry done
//   branch_mispredict/branch_rob_idx squash everything younger than the branch
//   commit_en/areg/new_preg/old_preg retirement port to the map / free list
//   rob_empty                       no valid entries
module reorder_buffer #(
  parameter int PREG_WIDTH = 7,
  parameter int AREG_WIDTH = 5,
  parameter int ROB_IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dispatch_valid,
  output logic                  dispatch_ready,
  input  logic                  dispatch_has_dest,
  input  logic [AREG_WIDTH-1:0] dispatch_areg,
  input  logic [PREG_WIDTH-1:0] dispatch_new_preg,
  input  logic [PREG_WIDTH-1:0] dispatch_old_preg,
  output logic [ROB_IDX_W-1:0]  dispatch_rob_idx,
  input  logic                  complete_valid,
  input  logic [ROB_IDX_W-1:0]  complete_rob_idx,
  input  logic                  branch_mispredict,
  input  logic [ROB_IDX_W-1:0]  branch_rob_idx,
  output logic                  commit_en,
  output logic [AREG_WIDTH-1:0] commit_areg,
  output logic [PREG_WIDTH-1:0] commit_new_preg,
  output logic [PREG_WIDTH-1:0] commit_old_preg,
  output logic                  rob_empty
);

  localparam int DEPTH = 2 ** ROB_IDX_W;
  localparam int PTR_W = ROB_IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]      head_ptr_r;
  logic [PTR_W-1:0]      tail_ptr_r;
  logic [PTR_W-1:0]      head_next_s;
  logic [PTR_W-1:0]      tail_next_s;
  logic [PTR_W-1:0]      count_s;
  logic [ROB_IDX_W-1:0]  head_idx_s;
  logic [ROB_IDX_W-1:0]  tail_idx_s;

  logic [DEPTH-1:0]      done_r;
  logic [DEPTH-1:0]      done_next_s;
  logic [DEPTH-1:0]      done_clear_s;
  logic [DEPTH-1:0]      done_set_s;

  logic [DEPTH-1:0]      has_dest_r;
  logic [AREG_WIDTH-1:0] areg_r     [DEPTH];
  logic [PREG_WIDTH-1:0] new_preg_r [DEPTH];
  logic [PREG_WIDTH-1:0] old_preg_r [DEPTH];

  logic                  dispatch_fire_s;
  logic                  commit_fire_s;
  logic                  empty_s;
  logic                  ready_s;

  assign head_idx_s = head_ptr_r[ROB_IDX_W-1:0];
  assign tail_idx_s = tail_ptr_r[ROB_IDX_W-1:0];
  assign count_s    = tail_ptr_r - head_ptr_r;
  assign empty_s    = (count_s == {PTR_W{1'b0}});
  // No full-bypass: a retiring head does not free its slot for this cycle.
  assign ready_s    = (count_s != FULL_COUNT);

  assign rob_empty        = empty_s;
  assign dispatch_ready   = ready_s;
  assign dispatch_rob_idx = tail_idx_s;

  assign dispatch_fire_s = dispatch_valid && ready_s && !branch_mispredict;
  // The reset term keeps the reset cycle free of a commit pulse even if the
  // head happens to be done.
  assign commit_fire_s   = !reset && !empty_s && done_r[head_idx_s] && !branch_mispredict;

  // Next-pointer selection: mispredict rewind, dispatch advance, commit advance.
  always_comb begin
    tail_next_s = tail_ptr_r;
    head_next_s = head_ptr_r;
    if (branch_mispredict) begin
      // Distance from head to branch is taken modulo DEPTH, then the branch
      // itself is kept by the +1.
      tail_next_s = head_ptr_r + {1'b0, branch_rob_idx - head_idx_s} + PTR_ONE;
    end else if (dispatch_fire_s) begin
      tail_next_s = tail_ptr_r + PTR_ONE;
    end else begin
      tail_next_s = tail_ptr_r;
    end
    if (commit_fire_s) begin
      head_next_s = head_ptr_r + PTR_ONE;
    end else begin
      head_next_s = head_ptr_r;
    end
  end

  // Done-bit update: dispatch clears the tail, completion and mispredict set.
  always_comb begin
    done_clear_s = {DEPTH{1'b0}};
    done_set_s   = {DEPTH{1'b0}};
    if (dispatch_fire_s) begin
      done_clear_s[tail_idx_s] = 1'b1;
    end else begin
      done_clear_s = {DEPTH{1'b0}};
    end
    if (complete_valid) begin
      done_set_s[complete_rob_idx] = 1'b1;
    end else begin
      done_set_s[complete_rob_idx] = 1'b0;
    end
    if (branch_mispredict) begin
      done_set_s[branch_rob_idx] = 1'b1;
    end else begin
      done_set_s[branch_rob_idx] = done_set_s[branch_rob_idx];
    end
    done_next_s = (done_r & ~done_clear_s) | done_set_s;
  end

  // Pointer and done-bit state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr_r <= {PTR_W{1'b0}};
      tail_ptr_r <= {PTR_W{1'b0}};
      done_r     <= {DEPTH{1'b0}};
    end else begin
      head_ptr_r <= head_next_s;
      tail_ptr_r <= tail_next_s;
      done_r     <= done_next_s;
    end
  end

  // Entry payload storage; contents only matter while the entry is valid.
  always_ff @(posedge clk) begin
    if (dispatch_fire_s) begin
      has_dest_r[tail_idx_s] <= dispatch_has_dest;
      areg_r[tail_idx_s]     <= dispatch_areg;
      new_preg_r[tail_idx_s] <= dispatch_new_preg;
      old_preg_r[tail_idx_s] <= dispatch_old_preg;
    end
  end

  // Retirement port: head payload while retiring, zeros otherwise.
  always_comb begin
    commit_en       = 1'b0;
    commit_areg     = {AREG_WIDTH{1'b0}};
    commit_new_preg = {PREG_WIDTH{1'b0}};
    commit_old_preg = {PREG_WIDTH{1'b0}};
    if (commit_fire_s) begin
      commit_en       = 1'b1;
      commit_areg     = areg_r[head_idx_s];
      commit_new_preg = new_preg_r[head_idx_s];
      // The free list ignores preg 0, so no-destination entries free nothing.
      if (has_dest_r[head_idx_s]) begin
        commit_old_preg = old_preg_r[head_idx_s];
      end else begin
        commit_old_preg = {PREG_WIDTH{1'b0}};
      end
    end else begin
      commit_en       = 1'b0;
      commit_areg     = {AREG_WIDTH{1'b0}};
      commit_new_preg = {PREG_WIDTH{1'b0}};
      commit_old_preg = {PREG_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic       clk;
  logic       reset;
  logic       dispatch_valid;
  logic       dispatch_ready;
  logic       dispatch_has_dest;
  logic [4:0] dispatch_areg;
  logic [6:0] dispatch_new_preg;
  logic [6:0] dispatch_old_preg;
  logic [3:0] dispatch_rob_idx;
  logic       complete_valid;
  logic [3:0] complete_rob_idx;
  logic       branch_mispredict;
  logic [3:0] branch_rob_idx;
  logic       commit_en;
  logic [4:0] commit_areg;
  logic [6:0] commit_new_preg;
  logic [6:0] commit_old_preg;
  logic       rob_empty;

  int checks;
  int errors;

  reorder_buffer #(.PREG_WIDTH(7), .AREG_WIDTH(5), .ROB_IDX_W(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_has_dest (dispatch_has_dest),
    .dispatch_areg     (dispatch_areg),
    .dispatch_new_preg (dispatch_new_preg),
    .dispatch_old_preg (dispatch_old_preg),
    .dispatch_rob_idx  (dispatch_rob_idx),
    .complete_valid    (complete_valid),
    .complete_rob_idx  (complete_rob_idx),
    .branch_mispredict (branch_mispredict),
    .branch_rob_idx    (branch_rob_idx),
    .commit_en         (commit_en),
    .commit_areg       (commit_areg),
    .commit_new_preg   (commit_new_preg),
    .commit_old_preg   (commit_old_preg),
    .rob_empty         (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled
  // mid-cycle, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_valid    = 1'b0;
    dispatch_has_dest = 1'b0;
    dispatch_areg     = 5'd0;
    dispatch_new_preg = 7'd0;
    dispatch_old_preg = 7'd0;
    complete_valid    = 1'b0;
    complete_rob_idx  = 4'd0;
    branch_mispredict = 1'b0;
    branch_rob_idx    = 4'd0;
  endtask

  task automatic set_dispatch(input logic hd, input logic [4:0] a,
                              input logic [6:0] np, input logic [6:0] op);
    dispatch_valid    = 1'b1;
    dispatch_has_dest = hd;
    dispatch_areg     = a;
    dispatch_new_preg = np;
    dispatch_old_preg = op;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", rob_empty); end
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", dispatch_ready); end
    checks++; if (dispatch_rob_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", dispatch_rob_idx); end
    checks++; if ({commit_en, commit_areg, commit_new_preg, commit_old_preg} !== 20'd0) begin
      errors++; $display("FAIL reset_commit en=%b areg=%0d new=%0d old=%0d exp=all0", commit_en, commit_areg, commit_new_preg, commit_old_preg);
    end
  endtask

  task automatic test_basic_order();
    do_reset();
    set_dispatch(1'b1, 5'd5, 7'd32, 7'd5);
    checks++; if (dispatch_rob_idx !== 4'd0) begin errors++; $display("FAIL basic_tag_a got=%0d exp=0", dispatch_rob_idx); end
    tick();
    set_dispatch(1'b1, 5'd6, 7'd33, 7'd6);
    checks++; if (dispatch_rob_idx !== 4'd1) begin errors++; $display("FAIL basic_tag_b got=%0d exp=1", dispatch_rob_idx); end
    tick();
    // C has no destination; its old_preg field must not reach the free list.
    set_dispatch(1'b0, 5'd7, 7'd40, 7'd9);
    tick();
    idle_inputs();
    complete_valid = 1'b1; complete_rob_idx = 4'd2;
    #1;
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL basic_no_commit_c got=%b exp=0", commit_en); end
    tick();
    complete_rob_idx = 4'd0;
    #1;
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL basic_no_commit_a got=%b exp=0", commit_en); end
    tick();
    complete_rob_idx = 4'd1;
    #1;
    checks++; if ({commit_en, commit_areg, commit_new_preg, commit_old_preg} !== {1'b1, 5'd5, 7'd32, 7'd5}) begin
      errors++; $display("FAIL basic_commit_a en=%b areg=%0d new=%0d old=%0d exp=1/5/32/5", commit_en, commit_areg, commit_new_preg, commit_old_preg);
    end
    tick();
    complete_valid = 1'b0;
    #1;
    checks++; if ({commit_en, commit_areg, commit_new_preg, commit_old_preg} !== {1'b1, 5'd6, 7'd33, 7'd6}) begin
      errors++; $display("FAIL basic_commit_b en=%b areg=%0d new=%0d old=%0d exp=1/6/33/6", commit_en, commit_areg, commit_new_preg, commit_old_preg);
    end
    tick();
    checks++; if ({commit_en, commit_areg, commit_new_preg, commit_old_preg} !== {1'b1, 5'd7, 7'd40, 7'd0}) begin
      errors++; $display("FAIL basic_commit_c en=%b areg=%0d new=%0d old=%0d exp=1/7/40/0", commit_en, commit_areg, commit_new_preg, commit_old_preg);
    end
    tick();
    checks++; if (rob_empty !== 1'b1 || commit_en !== 1'b0) begin
      errors++; $display("FAIL basic_drained empty=%b en=%b exp=1/0", rob_empty, commit_en);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_dispatch(1'b1, 5'(i + 1), 7'(64 + i), 7'(i + 1));
      checks++; if (dispatch_ready !== 1'b1 || dispatch_rob_idx !== 4'(i)) begin
        errors++; $display("FAIL full_fill_%0d ready=%b idx=%0d exp=1/%0d", i, dispatch_ready, dispatch_rob_idx, i);
      end
      tick();
    end
    checks++; if (dispatch_ready !== 1'b0 || rob_empty !== 1'b0) begin
      errors++; $display("FAIL full_flag ready=%b empty=%b exp=0/0", dispatch_ready, rob_empty);
    end
    // 17th dispatch must be dropped: tail tag stays at 0.
    set_dispatch(1'b1, 5'd31, 7'd127, 7'd127);
    tick();
    idle_inputs();
    #1;
    checks++; if (dispatch_ready !== 1'b0 || dispatch_rob_idx !== 4'd0) begin
      errors++; $display("FAIL full_drop ready=%b idx=%0d exp=0/0", dispatch_ready, dispatch_rob_idx);
    end
    complete_valid = 1'b1; complete_rob_idx = 4'd0;
    tick();
    complete_valid = 1'b0;
    #1;
    checks++; if ({commit_en, commit_areg, commit_new_preg, commit_old_preg} !== {1'b1, 5'd1, 7'd64, 7'd1}) begin
      errors++; $display("FAIL full_commit en=%b areg=%0d new=%0d old=%0d exp=1/1/64/1", commit_en, commit_areg, commit_new_preg, commit_old_preg);
    end
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", dispatch_ready); end
    tick();
    checks++; if (commit_en !== 1'b0 || dispatch_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_back en=%b ready=%b exp=0/1", commit_en, dispatch_ready);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_dispatch(1'b1, 5'(10 + i), 7'(80 + i), 7'(20 + i));
      tick();
    end
    idle_inputs();
    // Offer a dispatch during the squash; it must be ignored.
    set_dispatch(1'b1, 5'd30, 7'd100, 7'd101);
    branch_mispredict = 1'b1; branch_rob_idx = 4'd2;
    #1;
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL mp_commit_suppr got=%b exp=0", commit_en); end
    tick();
    idle_inputs();
    #1;
    checks++; if (dispatch_rob_idx !== 4'd3) begin errors++; $display("FAIL mp_tail got=%0d exp=3", dispatch_rob_idx); end
    complete_valid = 1'b1; complete_rob_idx = 4'd0;
    tick();
    complete_rob_idx = 4'd1;
    #1;
    checks++; if (commit_en !== 1'b1 || commit_areg !== 5'd10) begin errors++; $display("FAIL mp_ret0 en=%b areg=%0d exp=1/10", commit_en, commit_areg); end
    tick();
    complete_rob_idx = 4'd2;
    #1;
    checks++; if (commit_en !== 1'b1 || commit_areg !== 5'd11) begin errors++; $display("FAIL mp_ret1 en=%b areg=%0d exp=1/11", commit_en, commit_areg); end
    tick();
    complete_valid = 1'b0;
    #1;
    checks++; if (commit_en !== 1'b1 || commit_areg !== 5'd12 || commit_old_preg !== 7'd22) begin
      errors++; $display("FAIL mp_ret2 en=%b areg=%0d old=%0d exp=1/12/22", commit_en, commit_areg, commit_old_preg);
    end
    tick();
    checks++; if (commit_en !== 1'b0 || rob_empty !== 1'b1) begin
      errors++; $display("FAIL mp_exactly3 en=%b empty=%b exp=0/1", commit_en, rob_empty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    // Cycle i: dispatch entry i, complete entry i-1, expect entry i-2 to retire.
    for (int i = 0; i < 42; i++) begin
      idle_inputs();
      if (i < 40) set_dispatch(1'b1, 5'(i % 32), 7'(i + 1), 7'(i + 50));
      if (i >= 1 && i <= 40) begin
        complete_valid = 1'b1; complete_rob_idx = 4'((i - 1) % 16);
      end
      #1;
      if (i < 40) begin
        checks++; if (dispatch_rob_idx !== 4'(i % 16) || dispatch_ready !== 1'b1) begin
          errors++; $display("FAIL wrap_tag_%0d idx=%0d ready=%b exp=%0d/1", i, dispatch_rob_idx, dispatch_ready, i % 16);
        end
        checks++; if (rob_empty !== (i == 0)) begin
          errors++; $display("FAIL wrap_empty_%0d got=%b exp=%b", i, rob_empty, (i == 0));
        end
      end
      if (i >= 2) begin
        checks++; if (commit_en !== 1'b1 || commit_new_preg !== 7'(i - 1) || commit_old_preg !== 7'(i + 48)) begin
          errors++; $display("FAIL wrap_commit_%0d en=%b new=%0d old=%0d exp=1/%0d/%0d", i, commit_en, commit_new_preg, commit_old_preg, i - 1, i + 48);
        end
      end else begin
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL wrap_early_%0d got=%b exp=0", i, commit_en); end
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++; if (rob_empty !== 1'b1 || commit_en !== 1'b0) begin
      errors++; $display("FAIL wrap_drained empty=%b en=%b exp=1/0", rob_empty, commit_en);
    end
  endtask

  task automatic test_mispredict_head_done();
    do_reset();
    set_dispatch(1'b1, 5'd3, 7'd70, 7'd3);
    tick();
    set_dispatch(1'b1, 5'd4, 7'd71, 7'd4);
    tick();
    idle_inputs();
    complete_valid = 1'b1; complete_rob_idx = 4'd0;
    tick();
    idle_inputs();
    branch_mispredict = 1'b1; branch_rob_idx = 4'd1;
    #1;
    checks++; if (commit_en !== 1'b0 || commit_old_preg !== 7'd0) begin
      errors++; $display("FAIL mph_suppr en=%b old=%0d exp=0/0", commit_en, commit_old_preg);
    end
    tick();
    idle_inputs();
    #1;
    checks++; if (commit_en !== 1'b1 || commit_areg !== 5'd3 || commit_new_preg !== 7'd70) begin
      errors++; $display("FAIL mph_next en=%b areg=%0d new=%0d exp=1/3/70", commit_en, commit_areg, commit_new_preg);
    end
    tick();
    // The branch entry itself was marked done by the mispredict.
    checks++; if (commit_en !== 1'b1 || commit_areg !== 5'd4) begin
      errors++; $display("FAIL mph_branch en=%b areg=%0d exp=1/4", commit_en, commit_areg);
    end
    tick();
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL mph_empty got=%b exp=1", rob_empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_dispatch(1'b1, 5'(i + 1), 7'(90 + i), 7'(i + 1));
      tick();
    end
    idle_inputs();
    complete_valid = 1'b1; complete_rob_idx = 4'd0;
    tick();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse got=%b exp=0", commit_en); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (rob_empty !== 1'b1 || commit_en !== 1'b0 || dispatch_rob_idx !== 4'd0) begin
      errors++; $display("FAIL rmid_after empty=%b en=%b idx=%0d exp=1/0/0", rob_empty, commit_en, dispatch_rob_idx);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_order();
    test_full();
    test_mispredict();
    test_wrap();
    test_mispredict_head_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
